// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C register target.
// Holds the FSM state enum, the R/W bit position and reserved addresses.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_t;

  localparam int unsigned RW_BIT = 0;

  localparam logic [6:0] I2C_GENERAL_CALL = 7'h00;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-FF synchronizers on SCL/SDA plus a previous-value stage.
// Ports: clk, reset, scl_in, sda_in -> scl_rise, scl_fall, start_det, stop_det, sda_s.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_p;
  logic       sda_p;
  logic       scl_s;

  // Idle bus is high, so reset to 1 to avoid a fake edge out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_p  <= 1'b1;
      sda_p  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl_in};
      sda_ff <= {sda_ff[0], sda_in};
      scl_p  <= scl_ff[1];
      sda_p  <= sda_ff[1];
    end
  end

  assign scl_s = scl_ff[1];
  assign sda_s = sda_ff[1];

  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  // SDA moving while SCL is steadily high marks bus conditions.
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with 8-bit register pointer and auto-increment.
// Ports: clk, reset, scl_in, sda_in, sda_oe, reg_* host port, busy.
import i2c_pkg::*;

module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  i2c_tgt_state_t state;
  logic [7:0]     shreg;
  logic [3:0]     cnt;
  logic           rw;
  logic           scl_rise;
  logic           scl_fall;
  logic           start_det;
  logic           stop_det;
  logic           sda_s;
  logic [7:0]     nxt;
  logic           addr_hit;
  logic           rd_load;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign nxt = {shreg[6:0], sda_s};

  assign addr_hit = (nxt[7:1] == TARGET_ADDR)
                 && (nxt[7:1] != I2C_GENERAL_CALL);

  // Read data is fetched on the fall that also drives its MSB, so the
  // strobe is combinational and the host answers in the same cycle.
  assign rd_load = !reset && scl_fall
                && ((state == ST_ADDR_ACK && sda_oe && rw)
                 || state == ST_RDATA_ACK);

  assign reg_rd = rd_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      shreg     <= 8'h00;
      cnt       <= 4'd0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wr    <= 1'b0;
      reg_wdata <= 8'h00;
    end else begin
      reg_wr <= 1'b0;
      if (start_det) begin
        state  <= ST_ADDR;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          ST_ADDR: if (scl_rise) begin
            shreg <= nxt;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt <= 4'd0;
              rw  <= nxt[RW_BIT];
              if (addr_hit) begin
                state <= ST_ADDR_ACK;
                busy  <= 1'b1;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
          // First fall drives the ACK, second fall releases it.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            sda_oe <= ~sda_oe;
            if (sda_oe) begin
              cnt <= 4'd0;
              if (state == ST_PTR_ACK) begin
                state <= ST_WDATA;
              end else if (state == ST_WDATA_ACK) begin
                state    <= ST_WDATA;
                reg_addr <= reg_addr + 8'd1;
              end else if (!rw) begin
                state <= ST_PTR;
              end
            end
          end
          ST_PTR: if (scl_rise) begin
            shreg <= nxt;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt      <= 4'd0;
              reg_addr <= nxt;
              state    <= ST_PTR_ACK;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shreg <= nxt;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt       <= 4'd0;
              reg_wr    <= 1'b1;
              reg_wdata <= nxt;
              state     <= ST_WDATA_ACK;
            end
          end
          ST_RDATA: if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              state  <= ST_RDATA_ACK;
            end else begin
              sda_oe <= ~shreg[7];
              shreg  <= {shreg[6:0], 1'b0};
              cnt    <= cnt + 4'd1;
            end
          end
          ST_RDATA_ACK: if (scl_rise) begin
            if (sda_s) begin
              state <= ST_WAIT_STOP;
            end else begin
              reg_addr <= reg_addr + 8'd1;
            end
          end
          default: ;
        endcase
        // MSB goes out on the same fall that fetches the byte.
        if (rd_load) begin
          sda_oe <= ~reg_rdata[7];
          shreg  <= {reg_rdata[6:0], 1'b0};
          cnt    <= 4'd1;
          state  <= ST_RDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C master against a pointer/register model.
// Drives directed and $urandom transactions, checks ACKs, strobes and data.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam logic [6:0] TGT = 7'h42;

  logic       clk;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;

  logic [7:0] key;
  logic [7:0] m_ptr;
  logic [7:0] wbuf [8];
  logic [15:0] wr_q [$];
  int rd_cnt;
  int oe_cnt;
  int checks;
  int errors;

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = reg_addr ^ key;

  i2c_target_regs #(.TARGET_ADDR(TGT)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wr    (reg_wr),
    .reg_wdata (reg_wdata),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_wr) wr_q.push_back({reg_addr, reg_wdata});
    if (reg_rd) rd_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;
    repeat (6) @(negedge clk);
    scl_m = 1'b1;
    repeat (8) @(negedge clk);
    s = sda_line;
    repeat (2) @(negedge clk);
    scl_m = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!scl_m) begin
      sda_m = 1'b1;
      repeat (6) @(negedge clk);
      scl_m = 1'b1;
      repeat (8) @(negedge clk);
    end
    sda_m = 1'b0;
    repeat (8) @(negedge clk);
    scl_m = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    repeat (6) @(negedge clk);
    scl_m = 1'b1;
    repeat (8) @(negedge clk);
    sda_m = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(~mack, s);
  endtask

  task automatic do_write(input logic skip_start,
                          input logic [7:0] p,
                          input int n);
    logic a;
    logic [7:0] ea;
    wr_q.delete();
    if (!skip_start) bus_start();
    send_byte({TGT, 1'b0}, a);
    check("w_addr_ack", a, 1);
    check("w_busy", busy, 1);
    send_byte(p, a);
    check("w_ptr_ack", a, 1);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], a);
      check("w_data_ack", a, 1);
    end
    bus_stop();
    repeat (4) @(negedge clk);
    check("w_busy_end", busy, 0);
    check("w_count", wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      ea = p + 8'(i);
      check("w_pair", wr_q[i], {ea, wbuf[i]});
    end
    m_ptr = p + 8'(n);
  endtask

  task automatic do_read(input logic set_ptr,
                         input logic [7:0] p,
                         input int k);
    logic a;
    logic [7:0] b;
    logic [7:0] st;
    int rd0;
    bus_start();
    if (set_ptr) begin
      send_byte({TGT, 1'b0}, a);
      check("r_waddr_ack", a, 1);
      send_byte(p, a);
      check("r_ptr_ack", a, 1);
      bus_start();
      st = p;
    end else begin
      st = m_ptr;
    end
    rd0 = rd_cnt;
    send_byte({TGT, 1'b1}, a);
    check("r_addr_ack", a, 1);
    check("r_busy", busy, 1);
    for (int j = 0; j < k; j++) begin
      recv_byte(j < k - 1, b);
      check("r_data", b, (st + 8'(j)) ^ key);
    end
    check("r_oe_rel", sda_oe, 0);
    check("r_state", dut.state, ST_WAIT_STOP);
    check("r_rd_cnt", rd_cnt - rd0, k);
    m_ptr = st + 8'(k - 1);
    bus_stop();
    repeat (4) @(negedge clk);
    check("r_busy_end", busy, 0);
  endtask

  task automatic check_rst_outs();
    check("rst_oe", sda_oe, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wr", reg_wr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_rd", reg_rd, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    check_rst_outs();
    reset = 1'b0;
    m_ptr = 8'h00;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    scl_m = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  logic       a;
  logic       s;
  logic       got;
  logic [7:0] ab;
  int         oe0;
  int         rd0;
  int         n;

  initial begin
    checks = 0;
    errors = 0;
    rd_cnt = 0;
    oe_cnt = 0;
    m_ptr  = 8'h00;
    key    = 8'hFF;
    reset  = 1'b1;
    scl_m  = 1'b1;
    sda_m  = 1'b1;
    repeat (3) @(negedge clk);
    check_rst_outs();
    reset = 1'b0;
    repeat (4) @(negedge clk);

    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    do_write(1'b0, 8'h10, 2);

    key = 8'hFF;
    do_read(1'b1, 8'h20, 2);

    oe0 = oe_cnt;
    rd0 = rd_cnt;
    wr_q.delete();
    bus_start();
    send_byte({7'h50, 1'b0}, a);
    check("nak50_ack", a, 0);
    check("nak50_busy", busy, 0);
    send_byte(8'h12, a);
    check("nak50_byte2", a, 0);
    bus_stop();
    bus_start();
    send_byte({I2C_GENERAL_CALL, 1'b0}, a);
    check("gc_ack", a, 0);
    check("gc_busy", busy, 0);
    bus_stop();
    check("nak_oe", oe_cnt - oe0, 0);
    check("nak_rd", rd_cnt - rd0, 0);
    check("nak_wr", wr_q.size(), 0);

    wbuf[0] = 8'h01;
    wbuf[1] = 8'h02;
    wbuf[2] = 8'h03;
    do_write(1'b0, 8'hFF, 3);
    check("wrap_ptr", reg_addr, m_ptr);

    wr_q.delete();
    bus_start();
    send_byte({TGT, 1'b0}, a);
    send_byte(8'h33, a);
    ab = 8'hC7;
    for (int i = 7; i >= 4; i--) clk_bit(ab[i], s);
    bus_start();
    repeat (2) @(negedge clk);
    check("abort_state", dut.state, ST_ADDR);
    check("abort_busy", busy, 0);
    check("abort_wr", wr_q.size(), 0);
    wbuf[0] = 8'h99;
    do_write(1'b1, 8'h40, 1);

    wbuf[0] = 8'h11;
    do_write(1'b0, 8'h77, 1);
    check("pre_rst_addr", reg_addr, m_ptr);
    bus_start();
    ab = {TGT, 1'b0};
    for (int i = 7; i >= 0; i--) clk_bit(ab[i], s);
    repeat (2) @(negedge clk);
    check("ack_drive", sda_oe, 1);
    pulse_reset();

    key = 8'hFF;
    bus_start();
    send_byte({TGT, 1'b0}, a);
    send_byte(8'h20, a);
    bus_start();
    send_byte({TGT, 1'b1}, a);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!got) begin
        repeat (4) @(negedge clk);
        if (sda_oe) begin
          got = 1'b1;
        end else begin
          scl_m = 1'b1;
          repeat (10) @(negedge clk);
          scl_m = 1'b0;
          repeat (2) @(negedge clk);
        end
      end
    end
    check("rd0_seen", got, 1);
    check("rd0_addr", reg_addr, 8'h20);
    pulse_reset();

    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      do_write(1'b0, 8'($urandom), n);
      key = 8'($urandom);
      do_read(1'($urandom_range(0, 1)), 8'($urandom),
              $urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
